pp_uart_rx_fifo: RTL and testbench
==================================

PP_UART_RX_FIFO -- requirements
Module: pp_uart_rx_fifo

Interface
REQ-001 Parameters SHALL be: DEPTH 16 (FIFO entries); AW 4 (pointer width, log2 DEPTH); TOUT_TICKS 640 (uart_clk ticks of idle before timeout, 4 chars x 10 bits x 16).
REQ-002 clk  in  1  system clock; the one clock, 16x baud domain shared with pp_uart_receiver.
REQ-003 rst  in  1  asynchronous reset, active-high.
REQ-004 soft_rst  in  1  synchronous clear, active-low.
REQ-005 uart_clk  in  1  16x-baud tick enable, one clk cycle wide.
REQ-006 rec_dataH  in  8  received character from pp_uart_receiver, zero-extended for 5/6/7-bit frames.
REQ-007 rec_readyH  in  1  single-cycle pulse: new character on rec_dataH.
REQ-008 parity_err  in  2  receiver parity status, valid in the cycle after rec_readyH (00 none, 01 odd, 10 even).
REQ-009 rd_en  in  1  pop request from bus side.
REQ-010 clr_ovr  in  1  clears overrun flag.
REQ-011 rx_thresh  in  5  level-interrupt threshold; 0 disables.
REQ-012 rd_data  out  8  head-entry data (first-word-fall-through).
REQ-013 rd_perr  out  2  parity status stored with the head entry.
REQ-014 empty / full  out  1 each  FIFO status.
REQ-015 count  out  5  entries held, 0..16.
REQ-016 overrun  out  1  sticky: a character was dropped.
REQ-017 level_irq  out  1  count >= rx_thresh.
REQ-018 tout_irq  out  1  character timeout.

Function
REQ-019 The write strobe SHALL be rec_readyH delayed one clk (wr_q); on wr_q the block writes {parity_err, rec_dataH} at the write pointer, so data and parity status are captured together.
REQ-020 Storage SHALL be DEPTH x 10 bits; write and read pointers are AW bits and wrap from 15 to 0.
REQ-021 rd_data/rd_perr SHALL show the entry at the read pointer combinationally; when empty they show 0.
REQ-022 rd_en with empty=1 SHALL be ignored: no pointer or count change.
REQ-023 wr_q with full=1 and no accepted read SHALL drop the character and set overrun the next cycle; stored contents are unchanged.
REQ-024 wr_q and an accepted read in the same cycle SHALL both complete; count is unchanged, including when full.
REQ-025 wr_q and rd_en in the same cycle with empty=1 SHALL write only; there is no bypass, and the data becomes visible the next cycle.
REQ-026 count SHALL be a registered value: +1 on write only, -1 on read only. empty = (count==0); full = (count==16).
REQ-027 overrun SHALL stay set until clr_ovr; if clr_ovr and a new drop occur in the same cycle, the set wins.
REQ-028 level_irq SHALL be combinational: (rx_thresh!=0) && (count >= rx_thresh); a rx_thresh above 16 never asserts.
REQ-029 A 10-bit timeout counter SHALL clear on wr_q, on an accepted read, or while empty; otherwise it increments on each uart_clk tick and saturates at TOUT_TICKS.
REQ-030 tout_irq SHALL be 1 when the counter equals TOUT_TICKS; it drops in the cycle after the next write, accepted read, or empty.

Reset
REQ-031 rst=1 SHALL asynchronously clear pointers, count, wr_q, overrun and the timeout counter; outputs then read empty=1, full=0, count=0, overrun=0, level_irq=0, tout_irq=0, rd_data=0, rd_perr=0.
REQ-032 soft_rst=0 SHALL produce the same state synchronously at the next clk edge and overrides all other inputs that cycle.
REQ-033 Storage array contents SHALL NOT need a reset.
REQ-034 A reset during a wr_q cycle SHALL discard that character.

Verification
REQ-035 Write/read: pulse rec_readyH with rec_dataH=0x5A, then parity_err=01 the next cycle -> two cycles after the pulse, empty=0, count=1, rd_data=0x5A, rd_perr=01; rd_en -> empty=1, rd_data=0.
REQ-036 Fill/overrun: write 0x00..0x0F, then write 0xFF -> full=1, count=16, overrun=1; 16 reads return 0x00..0x0F in order; clr_ovr -> overrun=0.
REQ-037 Simultaneous events: at full, wr_q and rd_en in the same cycle -> count stays 16, overrun=0, last read returns the new byte. At empty, wr_q and rd_en together -> count=1.
REQ-038 Threshold: rx_thresh=4, write 4 bytes -> level_irq=1 after the 4th write; one read -> level_irq=0; rx_thresh=0 -> level_irq=0 at any count.
REQ-039 Timeout: write 1 byte, then hold uart_clk ticking with no traffic -> tout_irq=1 after 640 ticks; rd_en -> tout_irq=0 next cycle, empty=1.
REQ-040 Reset mid-fill: 5 bytes held, then soft_rst=0 for one cycle -> count=0, empty=1, overrun=0; then rst=1 mid-write -> same state, and the byte is not stored.

Source files
------------

// File: rtl/pp_uart_rx_fifo.sv
// Receive FIFO behind pp_uart_receiver: 16 x {parity, data} entries, first-word-fall-through
// head, sticky overrun, level threshold interrupt and idle character-timeout interrupt.
module pp_uart_rx_fifo #(
  parameter int DEPTH      = 16,
  parameter int AW         = 4,
  parameter int TOUT_TICKS = 640
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          soft_rst,
  input  logic          uart_clk,
  input  logic [7:0]    rec_dataH,
  input  logic          rec_readyH,
  input  logic [1:0]    parity_err,
  input  logic          rd_en,
  input  logic          clr_ovr,
  input  logic [4:0]    rx_thresh,
  output logic [7:0]    rd_data,
  output logic [1:0]    rd_perr,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overrun,
  output logic          level_irq,
  output logic          tout_irq
);

  localparam logic [AW:0] L_DEPTH = DEPTH[AW:0];
  localparam logic [9:0]  L_TOUT  = TOUT_TICKS[9:0];

  logic [9:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_wr_q;
  logic [7:0]    r_data_q;
  logic          r_ovr;
  logic [9:0]    r_tout;

  logic          w_empty;
  logic          w_full;
  logic          w_rd_acc;
  logic          w_wr_acc;
  logic          w_drop;
  logic [9:0]    w_head;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == L_DEPTH);
  assign w_rd_acc = rd_en && !w_empty;
  // A write into a full FIFO still fits when the head is popped in the same cycle.
  assign w_wr_acc = r_wr_q && (!w_full || w_rd_acc);
  assign w_drop   = r_wr_q && w_full && !w_rd_acc;
  assign w_head   = r_mem[r_rd_ptr];

  // Data is latched with the ready pulse; parity arrives one cycle later, together with wr_q.
  always_ff @(posedge clk) begin
    if (rec_readyH) r_data_q <= rec_dataH;
    if (w_wr_acc && soft_rst) r_mem[r_wr_ptr] <= {parity_err, r_data_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_q   <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovr    <= 1'b0;
      r_tout   <= '0;
    end else if (!soft_rst) begin
      r_wr_q   <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovr    <= 1'b0;
      r_tout   <= '0;
    end else begin
      r_wr_q <= rec_readyH;
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr_acc && !w_rd_acc)      r_count <= r_count + 1'b1;
      else if (w_rd_acc && !w_wr_acc) r_count <= r_count - 1'b1;
      if (w_drop)       r_ovr <= 1'b1;
      else if (clr_ovr) r_ovr <= 1'b0;
      if (r_wr_q || w_rd_acc || w_empty)     r_tout <= '0;
      else if (uart_clk && r_tout != L_TOUT) r_tout <= r_tout + 1'b1;
    end
  end

  assign rd_data   = w_empty ? 8'h00 : w_head[7:0];
  assign rd_perr   = w_empty ? 2'b00 : w_head[9:8];
  assign empty     = w_empty;
  assign full      = w_full;
  assign count     = r_count;
  assign overrun   = r_ovr;
  assign level_irq = (rx_thresh != '0) && (r_count >= rx_thresh);
  assign tout_irq  = (r_tout == L_TOUT);

endmodule

// File: tb/tb_pp_uart_rx_fifo.sv
// Directed bench for pp_uart_rx_fifo: one task per scenario with inline
// comparisons against hand-computed values.
module tb_pp_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       soft_rst = 1'b1;
  logic       uart_clk = 1'b0;
  logic [7:0] rec_dataH = 8'h00;
  logic       rec_readyH = 1'b0;
  logic [1:0] parity_err = 2'b00;
  logic       rd_en = 1'b0;
  logic       clr_ovr = 1'b0;
  logic [4:0] rx_thresh = 5'd0;
  logic [7:0] rd_data;
  logic [1:0] rd_perr;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic       level_irq;
  logic       tout_irq;

  int n_checks = 0;
  int n_fail   = 0;

  pp_uart_rx_fifo dut (
    .clk(clk), .rst(rst), .soft_rst(soft_rst), .uart_clk(uart_clk),
    .rec_dataH(rec_dataH), .rec_readyH(rec_readyH), .parity_err(parity_err),
    .rd_en(rd_en), .clr_ovr(clr_ovr), .rx_thresh(rx_thresh),
    .rd_data(rd_data), .rd_perr(rd_perr), .empty(empty), .full(full),
    .count(count), .overrun(overrun), .level_irq(level_irq), .tout_irq(tout_irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] d, input logic [1:0] p);
    rec_dataH  = d;
    rec_readyH = 1'b1;
    tick();
    rec_readyH = 1'b0;
    parity_err = p;
    tick();
    parity_err = 2'b00;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if ({overrun, level_irq, tout_irq} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {overrun, level_irq, tout_irq}); end
    n_checks++; if ({rd_perr, rd_data} !== 10'h000) begin n_fail++; $display("FAIL reset_head: got %h want 000", {rd_perr, rd_data}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    wr_byte(8'h5A, 2'b01);
    n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL wr_empty: got %b want 0", empty); end
    n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL wr_count: got %0d want 1", count); end
    n_checks++; if (rd_data !== 8'h5A) begin n_fail++; $display("FAIL wr_data: got %h want 5a", rd_data); end
    n_checks++; if (rd_perr !== 2'b01) begin n_fail++; $display("FAIL wr_perr: got %b want 01", rd_perr); end
    pop();
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rd_empty: got %b want 1", empty); end
    n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL rd_data_zero: got %h want 00", rd_data); end
    pop();
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL rd_at_empty_count: got %0d want 0", count); end
    wr_byte(8'h33, 2'b10);
    n_checks++; if ({rd_perr, rd_data} !== {2'b10, 8'h33}) begin n_fail++; $display("FAIL rd_at_empty_ptr: got %h want 233", {rd_perr, rd_data}); end
    pop();
  endtask

  task automatic test_fill_overrun();
    for (int i = 0; i < 16; i++) wr_byte(8'(i), 2'(i % 3));
    n_checks++; if ({full, count} !== {1'b1, 5'd16}) begin n_fail++; $display("FAIL fill_full: got full=%b count=%0d want 1/16", full, count); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL fill_no_ovr: got %b want 0", overrun); end
    wr_byte(8'hFF, 2'b11);
    n_checks++; if ({overrun, full, count} !== {1'b1, 1'b1, 5'd16}) begin n_fail++; $display("FAIL ovr_set: got ovr=%b full=%b count=%0d want 1/1/16", overrun, full, count); end
    rec_dataH = 8'hEE; rec_readyH = 1'b1;
    tick();
    rec_readyH = 1'b0; clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set_wins: got %b want 1", overrun); end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if ({rd_perr, rd_data} !== {2'(i % 3), 8'(i)}) begin
        n_fail++; $display("FAIL fill_order[%0d]: got %h want %h", i, {rd_perr, rd_data}, {2'(i % 3), 8'(i)});
      end
      pop();
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", empty); end
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", overrun); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 16; i++) wr_byte(8'h20 + 8'(i), 2'b00);
    rec_dataH = 8'hAB; rec_readyH = 1'b1;
    tick();
    rec_readyH = 1'b0; parity_err = 2'b10; rd_en = 1'b1;
    tick();
    rd_en = 1'b0; parity_err = 2'b00;
    n_checks++; if ({full, count, overrun} !== {1'b1, 5'd16, 1'b0}) begin n_fail++; $display("FAIL sim_full: got full=%b count=%0d ovr=%b want 1/16/0", full, count, overrun); end
    for (int i = 1; i < 16; i++) begin
      n_checks++;
      if (rd_data !== 8'h20 + 8'(i)) begin n_fail++; $display("FAIL sim_order[%0d]: got %h want %h", i, rd_data, 8'h20 + 8'(i)); end
      pop();
    end
    n_checks++; if ({rd_perr, rd_data} !== {2'b10, 8'hAB}) begin n_fail++; $display("FAIL sim_last: got %h want 2ab", {rd_perr, rd_data}); end
    pop();
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL sim_drain: got %b want 1", empty); end
    rec_dataH = 8'h77; rec_readyH = 1'b1;
    tick();
    rec_readyH = 1'b0; rd_en = 1'b1;
    n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL sim_no_bypass: got %h want 00", rd_data); end
    tick();
    rd_en = 1'b0;
    n_checks++; if ({count, rd_data} !== {5'd1, 8'h77}) begin n_fail++; $display("FAIL sim_empty: got count=%0d data=%h want 1/77", count, rd_data); end
    pop();
  endtask

  task automatic test_threshold();
    rx_thresh = 5'd4;
    for (int i = 0; i < 3; i++) wr_byte(8'h40 + 8'(i), 2'b00);
    n_checks++; if (level_irq !== 1'b0) begin n_fail++; $display("FAIL thr_below: got %b want 0", level_irq); end
    wr_byte(8'h43, 2'b00);
    n_checks++; if (level_irq !== 1'b1) begin n_fail++; $display("FAIL thr_at: got %b want 1", level_irq); end
    pop();
    n_checks++; if (level_irq !== 1'b0) begin n_fail++; $display("FAIL thr_after_rd: got %b want 0", level_irq); end
    wr_byte(8'h44, 2'b00);
    rx_thresh = 5'd0;
    #1;
    n_checks++; if (level_irq !== 1'b0) begin n_fail++; $display("FAIL thr_disabled: got %b want 0", level_irq); end
    rx_thresh = 5'd17;
    #1;
    n_checks++; if (level_irq !== 1'b0) begin n_fail++; $display("FAIL thr_17: got %b want 0", level_irq); end
    rx_thresh = 5'd3;
    #1;
    n_checks++; if (level_irq !== 1'b1) begin n_fail++; $display("FAIL thr_3: got %b want 1", level_irq); end
    rx_thresh = 5'd0;
    for (int i = 0; i < 4; i++) pop();
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL thr_drain: got %b want 1", empty); end
  endtask

  task automatic test_timeout();
    wr_byte(8'h99, 2'b00);
    for (int i = 0; i < 639; i++) begin
      uart_clk = 1'b1; tick(); uart_clk = 1'b0; tick();
    end
    n_checks++; if (tout_irq !== 1'b0) begin n_fail++; $display("FAIL tout_639: got %b want 0", tout_irq); end
    uart_clk = 1'b1; tick(); uart_clk = 1'b0; tick();
    n_checks++; if (tout_irq !== 1'b1) begin n_fail++; $display("FAIL tout_640: got %b want 1", tout_irq); end
    for (int i = 0; i < 5; i++) begin
      uart_clk = 1'b1; tick(); uart_clk = 1'b0;
    end
    n_checks++; if (tout_irq !== 1'b1) begin n_fail++; $display("FAIL tout_sat: got %b want 1", tout_irq); end
    rd_en = 1'b1;
    n_checks++; if (tout_irq !== 1'b1) begin n_fail++; $display("FAIL tout_hold_rd: got %b want 1", tout_irq); end
    tick();
    rd_en = 1'b0;
    n_checks++; if ({tout_irq, empty} !== 2'b01) begin n_fail++; $display("FAIL tout_clear: got tout=%b empty=%b want 0/1", tout_irq, empty); end
  endtask

  task automatic test_reset_mid_fill();
    for (int i = 0; i < 5; i++) wr_byte(8'h60 + 8'(i), 2'b01);
    n_checks++; if (count !== 5'd5) begin n_fail++; $display("FAIL mid_count5: got %0d want 5", count); end
    soft_rst = 1'b0; rd_en = 1'b1;
    tick();
    soft_rst = 1'b1; rd_en = 1'b0;
    n_checks++; if ({count, empty, overrun, rd_data} !== {5'd0, 1'b1, 1'b0, 8'h00}) begin n_fail++; $display("FAIL soft_rst: got count=%0d empty=%b ovr=%b data=%h want 0/1/0/00", count, empty, overrun, rd_data); end
    rec_dataH = 8'hC3; rec_readyH = 1'b1;
    tick();
    rec_readyH = 1'b0; parity_err = 2'b01;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
    parity_err = 2'b00;
    tick();
    n_checks++; if ({count, empty} !== {5'd0, 1'b1}) begin n_fail++; $display("FAIL rst_mid_write: got count=%0d empty=%b want 0/1", count, empty); end
    wr_byte(8'h11, 2'b00);
    n_checks++; if ({count, rd_data} !== {5'd1, 8'h11}) begin n_fail++; $display("FAIL rst_discard: got count=%0d data=%h want 1/11", count, rd_data); end
    pop();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_fill_overrun();
    test_simultaneous();
    test_threshold();
    test_timeout();
    test_reset_mid_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
